id_ex_skid_buffer: RTL and testbench

ID_EX_SKID_BUFFER -- requirements
Module: id_ex_skid_buffer

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/id_ex_skid_buffer.sv | 106 ++++++++++
 tb/tb_id_ex_skid_buffer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the ID->EX pipeline boundary: default data width,
// payload record and skid-buffer state encoding.
package pipe_pkg;

   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic              fp;
      logic [DATA_W-1:0] rs_msg;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] rt_msg;
      logic [DATA_W-1:0] rd_data;
   } payload_t;

   // Encoding equals the occupancy count so occ can be driven straight from state.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } buf_state_e;

endpackage

// File: rtl/id_ex_skid_buffer.sv
// Two-entry in-order skid buffer between ID and EX. The head register drives EX;
// the skid register absorbs one payload when EX stalls, so in_ready is purely registered.
module id_ex_skid_buffer
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = pipe_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_fp,
   input  logic [DATA_W-1:0] in_rs_msg,
   input  logic [DATA_W-1:0] in_rt_data,
   input  logic [DATA_W-1:0] in_rt_msg,
   input  logic [DATA_W-1:0] in_rd_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_fp,
   output logic [DATA_W-1:0] out_rs_msg,
   output logic [DATA_W-1:0] out_rt_data,
   output logic [DATA_W-1:0] out_rt_msg,
   output logic [DATA_W-1:0] out_rd_data,
   output logic [1:0]        occ
);

   // Local record so a non-default DATA_W still gets a correctly sized entry.
   typedef struct packed {
      logic              fp;
      logic [DATA_W-1:0] rs_msg;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] rt_msg;
      logic [DATA_W-1:0] rd_data;
   } entry_t;

   buf_state_e state_q, state_d;
   entry_t     head_q, head_d;
   entry_t     skid_q, skid_d;
   entry_t     in_entry;
   logic       push, pop;

   assign in_entry = '{fp: in_fp, rs_msg: in_rs_msg, rt_data: in_rt_data,
                       rt_msg: in_rt_msg, rd_data: in_rd_data};

   assign in_ready  = (state_q != StFull) && !rst;
   assign out_valid = (state_q != StEmpty);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         // Squash drops every held payload but leaves the data registers alone.
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (push) begin
                  head_d  = in_entry;
                  state_d = StOne;
               end
            end
            StOne: begin
               if (push && pop) begin
                  head_d = in_entry;
               end else if (push) begin
                  skid_d  = in_entry;
                  state_d = StFull;
               end else if (pop) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               if (pop) begin
                  head_d  = skid_q;
                  state_d = StOne;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StEmpty;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   assign out_fp      = head_q.fp;
   assign out_rs_msg  = head_q.rs_msg;
   assign out_rt_data = head_q.rt_data;
   assign out_rt_msg  = head_q.rt_msg;
   assign out_rd_data = head_q.rd_data;
   assign occ         = state_q;

endmodule

// File: tb/tb_id_ex_skid_buffer.sv
// Self-checking bench for id_ex_skid_buffer: directed scenarios plus a randomized
// run compared against a queue model of the buffer contents.
module tb_id_ex_skid_buffer;

   typedef struct packed {
      logic        fp;
      logic [31:0] rs_msg;
      logic [31:0] rt_data;
      logic [31:0] rt_msg;
      logic [31:0] rd_data;
   } pl_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_fp;
   logic [31:0] in_rs_msg, in_rt_data, in_rt_msg, in_rd_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic        out_fp;
   logic [31:0] out_rs_msg, out_rt_data, out_rt_msg, out_rd_data;
   logic [1:0]  occ;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_skid_buffer #(.DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_fp      (in_fp),
      .in_rs_msg  (in_rs_msg),
      .in_rt_data (in_rt_data),
      .in_rt_msg  (in_rt_msg),
      .in_rd_data (in_rd_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_fp     (out_fp),
      .out_rs_msg (out_rs_msg),
      .out_rt_data(out_rt_data),
      .out_rt_msg (out_rt_msg),
      .out_rd_data(out_rd_data),
      .occ        (occ)
   );

   function automatic pl_t out_pl();
      pl_t p;
      p.fp      = out_fp;
      p.rs_msg  = out_rs_msg;
      p.rt_data = out_rt_data;
      p.rt_msg  = out_rt_msg;
      p.rd_data = out_rd_data;
      return p;
   endfunction

   function automatic pl_t mk(input logic [31:0] rs);
      pl_t p;
      p.fp      = rs[0];
      p.rs_msg  = rs;
      p.rt_data = rs ^ 32'h5555_0000;
      p.rt_msg  = ~rs;
      p.rd_data = rs + 32'h100;
      return p;
   endfunction

   task automatic drive_in(input logic v, input pl_t p);
      in_valid   = v;
      in_fp      = p.fp;
      in_rs_msg  = p.rs_msg;
      in_rt_data = p.rt_data;
      in_rt_msg  = p.rt_msg;
      in_rd_data = p.rd_data;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive_in(1'b1, mk(32'h7));
      #2;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (occ !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occ); end
      checks++; if (out_pl() !== pl_t'(0)) begin failures++; $display("FAIL reset_data got=%0h exp=0", out_pl()); end
      @(posedge clk); #1;
      checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_hold occ=%0d valid=%0b exp=0/0", occ, out_valid); end
      @(negedge clk);
      rst = 1'b0;
      drive_in(1'b0, mk(32'h0));
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%0b exp=0", out_valid); end
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         drive_in(1'b1, mk(32'(i)));
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid_%0d got=%0b exp=1", i, out_valid); end
         checks++; if (out_pl() !== mk(32'(i))) begin failures++; $display("FAIL stream_data_%0d got=%0h exp=%0h", i, out_pl(), mk(32'(i))); end
         checks++; if (occ !== 2'd1) begin failures++; $display("FAIL stream_occ_%0d got=%0d exp=1", i, occ); end
      end
      drive_in(1'b0, mk(32'h0));
      @(negedge clk);
      checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain occ=%0d valid=%0b exp=0/0", occ, out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive_in(1'b1, mk(32'hA));
      @(negedge clk);
      checks++; if (occ !== 2'd1) begin failures++; $display("FAIL bp_occ1 got=%0d exp=1", occ); end
      drive_in(1'b1, mk(32'hB));
      @(negedge clk);
      checks++; if (occ !== 2'd2) begin failures++; $display("FAIL bp_occ2 got=%0d exp=2", occ); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
      checks++; if (out_pl() !== mk(32'hA)) begin failures++; $display("FAIL bp_head got=%0h exp=%0h", out_pl(), mk(32'hA)); end
      drive_in(1'b0, mk(32'h0));
      @(negedge clk);
      checks++; if (out_pl() !== mk(32'hA) || occ !== 2'd2) begin failures++; $display("FAIL bp_hold got=%0h occ=%0d exp=%0h/2", out_pl(), occ, mk(32'hA)); end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_pl() !== mk(32'hB) || occ !== 2'd1) begin failures++; $display("FAIL bp_second got=%0h occ=%0d exp=%0h/1", out_pl(), occ, mk(32'hB)); end
      @(negedge clk);
      checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain occ=%0d valid=%0b exp=0/0", occ, out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive_in(1'b1, mk(32'hC));
      @(negedge clk);
      drive_in(1'b1, mk(32'hD));
      @(negedge clk);
      checks++; if (occ !== 2'd2) begin failures++; $display("FAIL flush_fill got=%0d exp=2", occ); end
      flush = 1'b1; out_ready = 1'b1;
      drive_in(1'b1, mk(32'hE));
      @(negedge clk);
      flush = 1'b0;
      drive_in(1'b0, mk(32'h0));
      checks++; if (occ !== 2'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occ); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_delivery got=%0b exp=0", out_valid); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive_in(1'b1, mk(32'h11));
      @(negedge clk);
      drive_in(1'b1, mk(32'h22));
      @(negedge clk);
      drive_in(1'b0, mk(32'h0));
      checks++; if (occ !== 2'd2) begin failures++; $display("FAIL arst_fill got=%0d exp=2", occ); end
      #1 rst = 1'b1;
      #1;
      checks++; if (occ !== 2'd0) begin failures++; $display("FAIL arst_occ got=%0d exp=0", occ); end
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL arst_hs valid=%0b ready=%0b exp=0/0", out_valid, in_ready); end
      checks++; if (out_pl() !== pl_t'(0)) begin failures++; $display("FAIL arst_data got=%0h exp=0", out_pl()); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL arst_release ready=%0b valid=%0b exp=1/0", in_ready, out_valid); end
   endtask

   task automatic test_random();
      pl_t q[$];
      pl_t p;
      logic v, rdy, fl, do_push, do_pop;
      q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         checks++; if (occ !== 2'(q.size())) begin failures++; $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", cyc, occ, q.size()); end
         checks++; if (out_valid !== (q.size() > 0)) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, q.size() > 0); end
         checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, q.size() < 2); end
         if (q.size() > 0) begin
            checks++; if (out_pl() !== q[0]) begin failures++; $display("FAIL rand_head cyc=%0d got=%0h exp=%0h", cyc, out_pl(), q[0]); end
         end
         p.fp = 1'($urandom); p.rs_msg = $urandom; p.rt_data = $urandom;
         p.rt_msg = $urandom; p.rd_data = $urandom;
         v   = ($urandom_range(9, 0) < 7);
         rdy = ($urandom_range(9, 0) < 6);
         fl  = ($urandom_range(31, 0) == 0);
         drive_in(v, p);
         out_ready = rdy;
         flush     = fl;
         do_push = v && (q.size() < 2);
         do_pop  = rdy && (q.size() > 0);
         if (fl) begin
            q.delete();
         end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(p);
         end
         @(negedge clk);
      end
      flush = 1'b0;
      drive_in(1'b0, mk(32'h0));
   endtask

   initial begin
      in_valid = 1'b0; in_fp = 1'b0; in_rs_msg = '0; in_rt_data = '0;
      in_rt_msg = '0; in_rd_data = '0; flush = 1'b0; out_ready = 1'b0; rst = 1'b1;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
